alu_arbiter: RTL

- Shares the single ALU instance between two requesters: req0 is the main pipeline execute stage, req1 is the branch/compare unit.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU's iA/iB/iALUFun/iSign from registered operands.
- Captures oS/oZ/oV/oN after ALU_LAT cycles and returns the result to the granted requester through a response handshake.
- Sits between the execute-stage requesters and the ALU in the CPU datapath.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arbiter_rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFun codes, arbiter states and requester count.
package alu_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_GEZ = 6'b111001;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input grant picker: single valid always wins, ties go to i_ptr.
// ALU_ARB_FIXED_PRIO_EN makes req0 win every tie and ignores i_ptr.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_vld,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  always_comb begin
    o_gnt = i_vld;
    if (i_vld[0]) o_gnt = 2'b01;
  end
`else
  always_comb begin
    o_gnt = i_vld;
    if (i_vld == 2'b11) o_gnt = i_ptr ? 2'b10 : 2'b01;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; result returns ALU_LAT+1 cycles after accept, held until consumed.
// Round-robin on ties unless ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUN_W   = 6,
  parameter int ALU_LAT = 1
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [NUM_REQ-1:0]       iReqValid,
  output logic [NUM_REQ-1:0]       oReqReady,
  input  logic [NUM_REQ*WIDTH-1:0] iReqA,
  input  logic [NUM_REQ*WIDTH-1:0] iReqB,
  input  logic [NUM_REQ*FUN_W-1:0] iReqFun,
  input  logic [NUM_REQ-1:0]       iReqSign,
  output logic [WIDTH-1:0]         oAluA,
  output logic [WIDTH-1:0]         oAluB,
  output logic [FUN_W-1:0]         oAluFun,
  output logic                     oAluSign,
  input  logic [WIDTH-1:0]         iAluS,
  input  logic                     iAluZ,
  input  logic                     iAluV,
  input  logic                     iAluN,
  output logic [NUM_REQ-1:0]       oRspValid,
  input  logic [NUM_REQ-1:0]       iRspReady,
  output logic [WIDTH-1:0]         oRspS,
  output logic                     oRspZ,
  output logic                     oRspV,
  output logic                     oRspN,
  output logic                     oBusy
);

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_ptr;
  logic               w_accept, w_capture;
  logic               r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_op_a, r_op_b, r_rsp_s;
  logic [FUN_W-1:0]   r_op_fun;
  logic               r_op_sign, r_rsp_z, r_rsp_v, r_rsp_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_ptr;
  // Pointer names the requester preferred on the next tie: always the last loser.
  always_ff @(posedge iClk) begin
    if (!iRst_n)       r_ptr <= 1'b0;
    else if (w_accept) r_ptr <= ~w_gnt[1];
  end
  assign w_ptr = r_ptr;
`endif

  rr_arb2 u_arb (
    .i_vld (iReqValid),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    oReqReady   = '0;
    oRspValid   = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        oReqReady = w_gnt & {NUM_REQ{iRst_n}};
        if (|w_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        oRspValid[r_owner] = 1'b1;
        if (iRspReady[r_owner]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_fun  <= FUN_W'(ALU_ADD);
      r_op_sign <= 1'b0;
      r_rsp_s   <= '0;
      r_rsp_z   <= 1'b0;
      r_rsp_v   <= 1'b0;
      r_rsp_n   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner   <= w_gnt[1];
        r_cnt     <= CNT_LOAD;
        r_op_a    <= w_gnt[1] ? iReqA[2*WIDTH-1:WIDTH]   : iReqA[WIDTH-1:0];
        r_op_b    <= w_gnt[1] ? iReqB[2*WIDTH-1:WIDTH]   : iReqB[WIDTH-1:0];
        r_op_fun  <= w_gnt[1] ? iReqFun[2*FUN_W-1:FUN_W] : iReqFun[FUN_W-1:0];
        r_op_sign <= iReqSign[w_gnt[1]];
      end
      if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_rsp_s <= iAluS;
        r_rsp_z <= iAluZ;
        r_rsp_v <= iAluV;
        r_rsp_n <= iAluN;
      end
    end
  end

  assign oAluA    = r_op_a;
  assign oAluB    = r_op_b;
  assign oAluFun  = r_op_fun;
  assign oAluSign = r_op_sign;
  assign oRspS    = r_rsp_s;
  assign oRspZ    = r_rsp_z;
  assign oRspV    = r_rsp_v;
  assign oRspN    = r_rsp_n;
  assign oBusy    = (r_state != IDLE);

endmodule
